// File: rtl/hazard_scoreboard.sv
// Load-use stall and registered EX operand-forward selects for the ID->EX boundary.
// Tracks the writers now in EX (S1) and MEM (S2); the selects line up with the instruction in EX.
module hazard_scoreboard #(
  parameter int REG_BITS    = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_id_valid,
  input  logic [REG_BITS-1:0]    i_id_rX,
  input  logic                   i_id_rX_used,
  input  logic [REG_BITS-1:0]    i_id_rY,
  input  logic                   i_id_rY_used,
  input  logic [REG_BITS-1:0]    i_id_rO,
  input  logic                   i_id_writes,
  input  logic                   i_id_is_load,
  input  logic                   i_ex_flush,
  output logic                   o_stall,
  output logic [1:0]             o_fwd_X,
  output logic [1:0]             o_fwd_Y,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  // wr folds valid & writes together: a bubble is simply a non-writer
  typedef struct packed {
    logic                wr;
    logic [REG_BITS-1:0] ro;
    logic                ld;
  } ent_t;

  ent_t s1, s2, s1_nxt;
  logic m1x, m1y, m2x, m2y;
  logic issue;
  logic [1:0] sel_x, sel_y;

  assign m1x = s1.wr && (s1.ro == i_id_rX);
  assign m1y = s1.wr && (s1.ro == i_id_rY);
  assign m2x = s2.wr && (s2.ro == i_id_rX);
  assign m2y = s2.wr && (s2.ro == i_id_rY);

  // flush wins over stall; S1 clears asynchronously, so reset drops stall at once
  assign o_stall = i_id_valid && !i_ex_flush && s1.wr && s1.ld &&
                   ((i_id_rX_used && m1x) || (i_id_rY_used && m1y));
  assign issue   = i_id_valid && !o_stall && !i_ex_flush;

  always_comb begin
    s1_nxt = '0;
    sel_x  = 2'd0;
    sel_y  = 2'd0;
    if (issue) begin
      s1_nxt.wr = i_id_writes;
      s1_nxt.ro = i_id_rO;
      s1_nxt.ld = i_id_is_load;
      // youngest producer (EX) takes precedence over MEM
      if (i_id_rX_used) sel_x = m1x ? 2'd1 : (m2x ? 2'd2 : 2'd0);
      if (i_id_rY_used) sel_y = m1y ? 2'd1 : (m2y ? 2'd2 : 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1            <= '0;
      s2            <= '0;
      o_fwd_X       <= 2'd0;
      o_fwd_Y       <= 2'd0;
      o_stall_count <= '0;
    end else begin
      s2      <= s1;
      s1      <= s1_nxt;
      o_fwd_X <= sel_x;
      o_fwd_Y <= sel_y;
      if (o_stall && !(&o_stall_count))
        o_stall_count <= o_stall_count + 1'b1;
    end
  end

endmodule
